// File: rtl/decode_operand_stage_pkg.sv
// Shared decode definitions for the ID stage: opcodes, instruction field split,
// immediate extension and the registered ID/EX bundle layout.
package pipeline_pkg;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_LWU   = 6'h27;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LD    = 6'h37;
    localparam logic [5:0] OP_SD    = 6'h3F;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
    } instr_fields_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [5:0]      opcode;
        logic [5:0]      funct;
        logic [4:0]      shamt;
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic [XLEN-1:0] imm;
        logic [RAW-1:0]  dest;
        logic            reg_write;
        logic            is_load;
    } id_ex_t;

    function automatic instr_fields_t split_instr(input logic [31:0] instr);
        instr_fields_t f;
        f.opcode = instr[31:26];
        f.rs     = instr[25:21];
        f.rt     = instr[20:16];
        f.rd     = instr[15:11];
        f.shamt  = instr[10:6];
        f.funct  = instr[5:0];
        f.imm    = instr[15:0];
        return f;
    endfunction

    function automatic logic is_load_op(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU, OP_LD};
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
    endfunction

    function automatic logic is_alu_imm_op(input logic [5:0] op);
        return op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
    endfunction

    function automatic logic uses_rt_op(input logic [5:0] op);
        return (op == OP_RTYPE) || is_store_op(op) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic uses_rs_op(input logic [5:0] op);
        return !((op == OP_J) || (op == OP_JAL));
    endfunction

    // Logical immediates zero-extend, LUI fills the upper half, the rest sign-extend.
    function automatic logic [XLEN-1:0] ext_imm(input logic [5:0] op, input logic [15:0] imm);
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: return {{(XLEN-16){1'b0}}, imm};
            OP_LUI:                   return {imm, {(XLEN-16){1'b0}}};
            default:                  return {{(XLEN-16){imm[15]}}, imm};
        endcase
    endfunction

endpackage

// File: rtl/decode_operand_stage_if.sv
// ID/EX bundle between decode (master) and execute (slave); execute drives ex_hold back.
interface decode_operand_stage_if #(
    parameter int N  = 32,
    parameter int AW = 5
);
    logic          ex_hold;
    logic          ex_valid;
    logic [N-1:0]  ex_pc;
    logic [5:0]    ex_opcode;
    logic [5:0]    ex_funct;
    logic [4:0]    ex_shamt;
    logic [N-1:0]  ex_op_a;
    logic [N-1:0]  ex_op_b;
    logic [N-1:0]  ex_imm;
    logic [AW-1:0] ex_dest;
    logic          ex_reg_write;
    logic          ex_is_load;

    modport master (
        input  ex_hold,
        output ex_valid, ex_pc, ex_opcode, ex_funct, ex_shamt, ex_op_a, ex_op_b,
               ex_imm, ex_dest, ex_reg_write, ex_is_load
    );

    modport slave (
        output ex_hold,
        input  ex_valid, ex_pc, ex_opcode, ex_funct, ex_shamt, ex_op_a, ex_op_b,
               ex_imm, ex_dest, ex_reg_write, ex_is_load
    );
endinterface

// File: rtl/decode_operand_stage_hazard.sv
// Load-use detector: the instruction in decode reads a register that the load
// currently in ID/EX has not produced yet.
module hazard_unit #(
    parameter int AW = 5
) (
    input  logic          ex_valid,
    input  logic          ex_is_load,
    input  logic [AW-1:0] ex_dest,
    input  logic          if_valid,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    input  logic          uses_rs,
    input  logic          uses_rt,
    output logic          hazard
);
    logic rs_match;
    logic rt_match;

    assign rs_match = uses_rs && (ex_dest == rs);
    assign rt_match = uses_rt && (ex_dest == rt);
    assign hazard   = ex_valid && ex_is_load && (ex_dest != '0) && if_valid
                      && (rs_match || rt_match);
endmodule

// File: rtl/decode_operand_stage.sv
// Decode stage: splits IF/ID, resolves operands ($0 and WB bypass), detects
// load-use, and registers the ID/EX bundle. N must equal pipeline_pkg::XLEN.
module decode_operand_stage
    import pipeline_pkg::*;
#(
    parameter int N  = XLEN,
    parameter int AW = $clog2(N)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          if_valid,
    input  logic [31:0]   if_instr,
    input  logic [N-1:0]  if_pc,
    output logic          stall_out,
    input  logic          flush,
    output logic [AW-1:0] rf_addr1,
    output logic [AW-1:0] rf_addr2,
    input  logic [N-1:0]  rf_data1,
    input  logic [N-1:0]  rf_data2,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [N-1:0]  wb_data,
    decode_operand_stage_if.master ex
);
    id_ex_t        id_ex_reg;
    id_ex_t        id_ex_next;
    instr_fields_t fld;
    logic [AW-1:0] rd_addr  [2];
    logic [N-1:0]  rd_data  [2];
    logic [N-1:0]  operand  [2];
    logic [AW-1:0] dest;
    logic          hazard;

    assign fld        = split_instr(if_instr);
    assign rf_addr1   = fld.rs;
    assign rf_addr2   = fld.rt;
    assign rd_addr[0] = fld.rs;
    assign rd_addr[1] = fld.rt;
    assign rd_data[0] = rf_data1;
    assign rd_data[1] = rf_data2;

    // The register file writes on the edge but reads asynchronously, so a
    // same-cycle writeback must be forwarded here; $0 is not hardwired there.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            assign operand[gi] = (rd_addr[gi] == '0)                  ? '0 :
                                 (wb_we && (wb_addr == rd_addr[gi])) ? wb_data :
                                                                       rd_data[gi];
        end
    endgenerate

    always_comb begin
        dest = '0;
        if (fld.opcode == OP_RTYPE)
            dest = fld.rd;
        else if (is_load_op(fld.opcode) || is_alu_imm_op(fld.opcode))
            dest = fld.rt;
    end

    hazard_unit #(.AW(AW)) u_hazard (
        .ex_valid   (id_ex_reg.valid),
        .ex_is_load (id_ex_reg.is_load),
        .ex_dest    (id_ex_reg.dest),
        .if_valid   (if_valid),
        .rs         (fld.rs),
        .rt         (fld.rt),
        .uses_rs    (uses_rs_op(fld.opcode)),
        .uses_rt    (uses_rt_op(fld.opcode)),
        .hazard     (hazard)
    );

    assign stall_out = (hazard || ex.ex_hold) && !flush;

    always_comb begin
        id_ex_next = id_ex_reg;
        if (flush) begin
            id_ex_next = '0;
        end else if (!ex.ex_hold) begin
            if (hazard) begin
                id_ex_next = '0;
            end else begin
                id_ex_next.valid     = if_valid;
                id_ex_next.pc        = if_pc;
                id_ex_next.opcode    = fld.opcode;
                id_ex_next.funct     = fld.funct;
                id_ex_next.shamt     = fld.shamt;
                id_ex_next.op_a      = operand[0];
                id_ex_next.op_b      = operand[1];
                id_ex_next.imm       = ext_imm(fld.opcode, fld.imm);
                id_ex_next.dest      = dest;
                id_ex_next.reg_write = (dest != '0);
                id_ex_next.is_load   = is_load_op(fld.opcode);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            id_ex_reg <= '0;
        else
            id_ex_reg <= id_ex_next;
    end

    assign ex.ex_valid     = id_ex_reg.valid;
    assign ex.ex_pc        = id_ex_reg.pc;
    assign ex.ex_opcode    = id_ex_reg.opcode;
    assign ex.ex_funct     = id_ex_reg.funct;
    assign ex.ex_shamt     = id_ex_reg.shamt;
    assign ex.ex_op_a      = id_ex_reg.op_a;
    assign ex.ex_op_b      = id_ex_reg.op_b;
    assign ex.ex_imm       = id_ex_reg.imm;
    assign ex.ex_dest      = id_ex_reg.dest;
    assign ex.ex_reg_write = id_ex_reg.reg_write;
    assign ex.ex_is_load   = id_ex_reg.is_load;
endmodule

// File: doc/decode_operand_stage.md
Name: decode_operand_stage

Overview:
- Instruction-decode stage of the pipeline; sits directly downstream of register_file and consumes its readData1/readData2.
- Splits the IF/ID instruction, drives the register-file read addresses, and forces $0 to zero because register_file does not hardwire it.
- Bypasses the same-cycle writeback value, detects load-use hazards, and registers a decoded ID/EX bundle for the execute stage.

Parameters:
N, 32, datapath width; must match register_file N
AW, $clog2(N), register address width (5 at default)

Ports:
CLK  input  1  clock; all state updates on posedge
RESET  input  1  asynchronous, active-high reset
if_valid  input  1  if_instr/if_pc hold a real instruction
if_instr  input  32  instruction word from IF/ID
if_pc  input  N  PC of if_instr
stall_out  output  1  IF/ID must hold (hazard or downstream hold)
flush  input  1  kill the instruction in decode (branch redirect)
ex_hold  input  1  execute stage not accepting; freeze ID/EX
rf_addr1  output  AW  register_file address1 = rs
rf_addr2  output  AW  register_file address2 = rt
rf_data1  input  N  register_file readData1
rf_data2  input  N  register_file readData2
wb_we  input  1  writeback write enable (same signals as register_file writeEnable)
wb_addr  input  AW  writeback address
wb_data  input  N  writeback data
ex_valid  output  1  ID/EX bundle valid
ex_pc  output  N  registered PC
ex_opcode  output  6  instr[31:26]
ex_funct  output  6  instr[5:0]
ex_shamt  output  5  instr[10:6]
ex_op_a  output  N  resolved rs operand
ex_op_b  output  N  resolved rt operand
ex_imm  output  N  extended immediate
ex_dest  output  AW  destination register (0 = none)
ex_reg_write  output  1  instruction writes ex_dest
ex_is_load  output  1  instruction is a load

Behaviour:
- Fields: rs=instr[25:21], rt=instr[20:16], rd=instr[15:11], imm=instr[15:0]. rf_addr1/rf_addr2 are combinational from if_instr.
- Operand resolve, combinational, per port: if address==0 -> 0; else if wb_we && wb_addr==address -> wb_data; else rf_dataX. The bypass is required because register_file writes at the clock edge and reads asynchronously.
- Immediate:
  - ANDI/ORI/XORI: zero-extend.
  - LUI: imm<<16, zero-filled.
  - Otherwise: sign-extend to N.
- Dest/reg_write:
  - opcode 0 (R-type): rd, reg_write=1.
  - Loads and ALU-immediate ops: rt, reg_write=1.
  - Stores, branches, J: dest=0, reg_write=0.
  - reg_write is forced 0 when the computed dest is 0.
- Loads: LB, LH, LW, LBU, LHU, LWU, LD.
- Uses-rt: R-type, stores, BEQ, BNE. All instructions except J/JAL use rs.
- Load-use hazard (comb): ex_valid && ex_is_load && ex_dest!=0 && if_valid && (ex_dest==rs || (uses_rt && ex_dest==rt)).
- stall_out = (hazard || ex_hold) && !flush.
- ID/EX update priority at posedge, highest first:
  1. RESET (async): every output register = 0, ex_valid=0.
  2. flush: ex_valid<=0; other fields don't-care (driven 0). Flush overrides ex_hold and hazard.
  3. ex_hold: all ID/EX registers keep their values.
  4. hazard: ex_valid<=0 (bubble); the instruction stays in IF/ID and is re-evaluated next cycle with fresh reads.
  5. else: ex_valid<=if_valid; fields load from the decode of if_instr.
- Latency: 1 cycle from if_instr to ex_*. One bubble per load-use. The hazard clears the cycle after the bubble because the load's ex_valid-as-load has moved on.
- During a hold the captured operands are not re-read. A WB to the same register during the hold does not alter ex_op_a/ex_op_b.
- RESET deasserting mid-stream: the first post-reset edge behaves as the normal case; no state is remembered.

Decomposition:
- Package pipeline_pkg holds:
  - opcode localparams: OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU, OP_LD, store opcodes.
  - a packed id_ex_t struct for the registered bundle.
  - field-extract functions.
- One sub-module, hazard_unit: the combinational load-use compare producing the hazard signal.

Test Plan:
- Reset mid-stream: assert RESET asynchronously between edges -> ex_valid=0, ex_op_a=0, stall_out=0 immediately, without waiting for an edge.
- $0 forcing: instr ADD $3,$0,$0 with rf_data1=rf_data2=32'hDEADBEEF -> ex_op_a=ex_op_b=0, ex_dest=3, ex_reg_write=1.
- WB bypass: ADDI $5,$4,-1 with rf_data1=7, wb_we=1, wb_addr=4, wb_data=32'h100 -> ex_op_a=32'h100, ex_imm=32'hFFFFFFFF.
- Load-use: LW $2,0($1) then ADD $3,$2,$2 -> second cycle stall_out=1 and ex_valid=0 bubble; next cycle ex_valid=1 with the ADD.
- Flush vs hold: ex_hold=1 and flush=1 together -> ex_valid=0 next edge, stall_out=0; ex_hold alone keeps every ex_* stable over 3 cycles.
